// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: gshare direction predictor with a direct-mapped BTB
module gshare_btb_predictor #(
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_BITS    = 5,
  parameter int CNT_BITS    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic [31:0]         predicted_next_pc,
  output logic                predicted_branch_taken,
  output logic [PHT_BITS-1:0] predicted_bhr,
  input  logic                update_valid,
  input  logic                update_is_jump,
  input  logic [31:0]         pc_for_update,
  input  logic [31:0]         update_next_pc,
  input  logic                update_taken,
  input  logic [PHT_BITS-1:0] update_bhr
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam int PHT_N = 2 ** PHT_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [BTB_ENTRIES-1:0] r_jump;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  logic [CNT_BITS-1:0]    r_pht    [PHT_N];
  logic [PHT_BITS-1:0]    r_bhr;
  logic [IDX-1:0]         w_bi, w_ubi;
  logic [PHT_BITS-1:0]    w_pi, w_upi;
  logic                   w_hit, w_taken;
  logic [CNT_BITS-1:0]    w_ucnt, w_cnt_next;
  logic [PHT_BITS:0]      w_bhr_shift;
  logic                   w_unused;
  assign w_unused = ^pc_for_update[1:0];
  // prediction path: purely combinational from current_pc and live state
  always_comb begin
    w_bi = current_pc[IDX+1:2];
    w_pi = current_pc[PHT_BITS+1:2] ^ r_bhr;
    w_hit = r_valid[w_bi] && (r_tag[w_bi] == current_pc[31:IDX+2]);
    w_taken = w_hit && (r_jump[w_bi] || r_pht[w_pi][CNT_BITS-1]);
    predicted_branch_taken = w_taken;
    predicted_next_pc = w_taken ? r_target[w_bi] : current_pc + 32'd4;
    predicted_bhr = r_bhr;
  end
  // update-side indices, saturating counter step and shifted history
  always_comb begin
    w_ubi = pc_for_update[IDX+1:2];
    w_upi = pc_for_update[PHT_BITS+1:2] ^ update_bhr;
    w_ucnt = r_pht[w_upi];
    w_cnt_next = update_taken ? ((w_ucnt == '1) ? w_ucnt : w_ucnt + CNT_ONE)
                              : ((w_ucnt == '0) ? w_ucnt : w_ucnt - CNT_ONE);
    w_bhr_shift = {r_bhr, update_taken};
  end
  // resettable state: valid bits, counters and history; reset beats update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_bhr <= '0;
      for (int k = 0; k < PHT_N; k++) r_pht[k] <= CNT_INIT;
    end else if (update_valid) begin
      if (update_taken) r_valid[w_ubi] <= 1'b1;
      if (!update_is_jump) begin
        r_pht[w_upi] <= w_cnt_next;
        r_bhr <= w_bhr_shift[PHT_BITS-1:0];
      end
    end
  end
  // BTB payload needs no reset since valid gates every use
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      r_tag[w_ubi] <= pc_for_update[31:IDX+2];
      r_target[w_ubi] <= update_next_pc;
      r_jump[w_ubi] <= update_is_jump;
    end
  end
endmodule
